// File: rtl/rf_pkg.sv
// Shared types and constants for the register file / operand bypass unit.
package rf_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned NREG_DEF = 32;

  typedef enum logic [2:0] {
    FWD_RF,
    FWD_WB,
    FWD_MEM,
    FWD_EX,
    FWD_ZERO
  } fwd_src_e;

  // Address width for a register count; never narrower than one bit.
  function automatic int unsigned addr_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rf_fwd_sel.sv
// Per-port forwarding source select and load-use hazard detect.
module rf_fwd_sel
  import rf_pkg::*;
#(
  parameter int unsigned AW       = 5,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic [AW-1:0] rs,
  input  logic          rs_used,
  input  logic          ex_regwrite,
  input  logic          ex_memread,
  input  logic [AW-1:0] ex_rd,
  input  logic          mem_regwrite,
  input  logic [AW-1:0] mem_rd,
  input  logic          wb_regwrite,
  input  logic [AW-1:0] wb_rd,
  output fwd_src_e      src_c,
  output logic          hazard_c
);

  logic ex_hit;
  logic mem_hit;
  logic wb_hit;

  assign ex_hit  = ex_regwrite  && (ex_rd  == rs);
  assign mem_hit = mem_regwrite && (mem_rd == rs);
  assign wb_hit  = wb_regwrite  && (wb_rd  == rs);

  // A load in EX shadows older MEM/WB producers, so it still raises the hazard.
  always_comb begin
    src_c    = FWD_RF;
    hazard_c = 1'b0;
    if (ZERO_REG && (rs == '0)) begin
      src_c = FWD_ZERO;
    end else begin
      if (ex_hit && !ex_memread) begin
        src_c = FWD_EX;
      end else if (mem_hit) begin
        src_c = FWD_MEM;
      end else if (wb_hit) begin
        src_c = FWD_WB;
      end
      hazard_c = rs_used && ex_hit && ex_memread;
    end
  end

endmodule

// File: rtl/rf_bypass_unit.sv
// Register file with EX/MEM/WB operand bypass, load-use interlock and registered operands.
module rf_bypass_unit
  import rf_pkg::*;
#(
  parameter int unsigned XLEN     = XLEN_DEF,
  parameter int unsigned NREG     = NREG_DEF,
  parameter int unsigned NRP      = 2,
  parameter bit          ZERO_REG = 1'b1,
  parameter int unsigned CW       = 16,
  localparam int unsigned AW      = addr_w(NREG)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                id_valid,
  input  logic [NRP*AW-1:0]   id_rs,
  input  logic [NRP-1:0]      id_rs_used,
  input  logic                flush,
  input  logic                ex_regwrite,
  input  logic                ex_memread,
  input  logic [AW-1:0]       ex_rd,
  input  logic [XLEN-1:0]     ex_result,
  input  logic                mem_regwrite,
  input  logic [AW-1:0]       mem_rd,
  input  logic [XLEN-1:0]     mem_result,
  input  logic                wb_regwrite,
  input  logic [AW-1:0]       wb_rd,
  input  logic [XLEN-1:0]     wb_data,
  output logic                stall,
  output logic                op_valid,
  output logic [NRP*XLEN-1:0] op_data,
  output logic [CW-1:0]       stall_count
);

  logic [XLEN-1:0]     rf [NREG];
  logic [NRP*XLEN-1:0] operand_c;
  logic [NRP-1:0]      hazard_c;
  logic                issue_c;

  for (genvar p = 0; p < NRP; p++) begin : g_port
    logic [AW-1:0]   rs;
    fwd_src_e        src;
    logic [XLEN-1:0] opnd;

    assign rs = id_rs[p*AW +: AW];

    rf_fwd_sel #(
      .AW       (AW),
      .ZERO_REG (ZERO_REG)
    ) u_sel (
      .rs           (rs),
      .rs_used      (id_rs_used[p]),
      .ex_regwrite  (ex_regwrite),
      .ex_memread   (ex_memread),
      .ex_rd        (ex_rd),
      .mem_regwrite (mem_regwrite),
      .mem_rd       (mem_rd),
      .wb_regwrite  (wb_regwrite),
      .wb_rd        (wb_rd),
      .src_c        (src),
      .hazard_c     (hazard_c[p])
    );

    always_comb begin
      opnd = rf[rs];
      case (src)
        FWD_ZERO: opnd = '0;
        FWD_EX:   opnd = ex_result;
        FWD_MEM:  opnd = mem_result;
        FWD_WB:   opnd = wb_data;
        default:  opnd = rf[rs];
      endcase
    end

    assign operand_c[p*XLEN +: XLEN] = opnd;
  end

  // Gated by reset so the hold request drops the instant reset asserts.
  assign stall   = id_valid && (|hazard_c) && !flush && reset;
  assign issue_c = id_valid && !stall && !flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(NREG); i++) begin
        rf[i] <= '0;
      end
    end else if (wb_regwrite && !(ZERO_REG && (wb_rd == '0))) begin
      rf[wb_rd] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_valid <= 1'b0;
      op_data  <= '0;
    end else if (issue_c) begin
      op_valid <= 1'b1;
      op_data  <= operand_c;
    end else begin
      op_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count <= '0;
    end else if (stall && (stall_count != '1)) begin
      stall_count <= stall_count + CW'(1);
    end
  end

endmodule

// File: tb/tb_rf_bypass_unit.sv
// Bench for rf_bypass_unit: directed scenarios plus random traffic against a rule-level model.
module tb_rf_bypass_unit;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 32;
  localparam int unsigned NRP  = 2;
  localparam int unsigned CW   = 4;
  localparam int unsigned AW   = 5;

  logic                clk;
  logic                reset;
  logic                id_valid;
  logic [NRP*AW-1:0]   id_rs;
  logic [NRP-1:0]      id_rs_used;
  logic                flush;
  logic                ex_regwrite;
  logic                ex_memread;
  logic [AW-1:0]       ex_rd;
  logic [XLEN-1:0]     ex_result;
  logic                mem_regwrite;
  logic [AW-1:0]       mem_rd;
  logic [XLEN-1:0]     mem_result;
  logic                wb_regwrite;
  logic [AW-1:0]       wb_rd;
  logic [XLEN-1:0]     wb_data;
  logic                stall;
  logic                op_valid;
  logic [NRP*XLEN-1:0] op_data;
  logic [CW-1:0]       stall_count;

  int errors = 0;
  int checks = 0;

  logic [XLEN-1:0]     m_rf [NREG];
  logic [NRP*XLEN-1:0] m_op;
  logic                m_valid;
  logic [CW-1:0]       m_cnt;

  rf_bypass_unit #(
    .XLEN     (XLEN),
    .NREG     (NREG),
    .NRP      (NRP),
    .ZERO_REG (1'b1),
    .CW       (CW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rs_used   (id_rs_used),
    .flush        (flush),
    .ex_regwrite  (ex_regwrite),
    .ex_memread   (ex_memread),
    .ex_rd        (ex_rd),
    .ex_result    (ex_result),
    .mem_regwrite (mem_regwrite),
    .mem_rd       (mem_rd),
    .mem_result   (mem_result),
    .wb_regwrite  (wb_regwrite),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .stall        (stall),
    .op_valid     (op_valid),
    .op_data      (op_data),
    .stall_count  (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    id_valid = 1'b0; id_rs = '0; id_rs_used = '0; flush = 1'b0;
    ex_regwrite = 1'b0; ex_memread = 1'b0; ex_rd = '0; ex_result = '0;
    mem_regwrite = 1'b0; mem_rd = '0; mem_result = '0;
    wb_regwrite = 1'b0; wb_rd = '0; wb_data = '0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(NREG); i++) m_rf[i] = '0;
    m_op = '0; m_valid = 1'b0; m_cnt = '0;
  endtask

  // Newest producer wins; a load still in EX has no data yet and r0 is always zero.
  function automatic logic [XLEN-1:0] m_operand(input logic [AW-1:0] rs);
    if (rs == 0) return '0;
    if (ex_regwrite && !ex_memread && ex_rd == rs) return ex_result;
    if (mem_regwrite && mem_rd == rs) return mem_result;
    if (wb_regwrite && wb_rd == rs) return wb_data;
    return m_rf[rs];
  endfunction

  // Inputs are set just after a falling edge; check stall, clock once, check registered outputs.
  task automatic step(input string tag);
    logic [NRP*XLEN-1:0] nxt;
    logic [AW-1:0]       rs;
    logic                haz;
    logic                exp_stall;
    #1;
    haz = 1'b0;
    nxt = '0;
    for (int p = 0; p < int'(NRP); p++) begin
      rs = id_rs[p*AW +: AW];
      nxt[p*XLEN +: XLEN] = m_operand(rs);
      if (id_rs_used[p] && rs != 0 && ex_regwrite && ex_memread && ex_rd == rs) haz = 1'b1;
    end
    exp_stall = id_valid && haz && !flush;
    chk({tag, " stall"}, 64'(stall), 64'(exp_stall));
    @(posedge clk);
    if (id_valid && !exp_stall && !flush) begin
      m_op = nxt;
      m_valid = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
    if (wb_regwrite && wb_rd != 0) m_rf[wb_rd] = wb_data;
    if (exp_stall && m_cnt != '1) m_cnt = m_cnt + 1'b1;
    #1;
    chk({tag, " op_valid"}, 64'(op_valid), 64'(m_valid));
    chk({tag, " op_data"}, 64'(op_data), 64'(m_op));
    chk({tag, " stall_count"}, 64'(stall_count), 64'(m_cnt));
    @(negedge clk);
  endtask

  initial begin
    idle();
    model_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset op_valid", 64'(op_valid), 64'd0);
    chk("reset op_data", 64'(op_data), 64'd0);
    chk("reset stall_count", 64'(stall_count), 64'd0);
    chk("reset stall", 64'(stall), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // Cold read of r5.
    id_valid = 1'b1; id_rs = {5'd5, 5'd5}; id_rs_used = 2'b11;
    step("read_r5");
    chk("read_r5 value", 64'(op_data), 64'd0);
    chk("read_r5 valid", 64'(op_valid), 64'd1);

    // Same-cycle WB write-through, then plain array read.
    idle();
    id_valid = 1'b1; id_rs = {5'd0, 5'd3}; id_rs_used = 2'b01;
    wb_regwrite = 1'b1; wb_rd = 5'd3; wb_data = 32'h1234;
    step("wb_thru");
    chk("wb_thru value", 64'(op_data[31:0]), 64'h1234);
    idle();
    id_valid = 1'b1; id_rs = {5'd3, 5'd0}; id_rs_used = 2'b10;
    step("rf_read_r3");
    chk("rf_read_r3 value", 64'(op_data[63:32]), 64'h1234);

    // All three stages write r7; EX wins.
    idle();
    id_valid = 1'b1; id_rs = {5'd7, 5'd7}; id_rs_used = 2'b11;
    ex_regwrite = 1'b1; ex_rd = 5'd7; ex_result = 32'hAAAA;
    mem_regwrite = 1'b1; mem_rd = 5'd7; mem_result = 32'hBBBB;
    wb_regwrite = 1'b1; wb_rd = 5'd7; wb_data = 32'hCCCC;
    step("prio_r7");
    chk("prio_r7 value", 64'(op_data), {32'hAAAA, 32'hAAAA});

    // Load-use on port 1, then the load moves into MEM.
    idle();
    id_valid = 1'b1; id_rs = {5'd4, 5'd1}; id_rs_used = 2'b11;
    ex_regwrite = 1'b1; ex_memread = 1'b1; ex_rd = 5'd4;
    #1 chk("loaduse stall now", 64'(stall), 64'd1);
    step("loaduse");
    chk("loaduse op_valid", 64'(op_valid), 64'd0);
    chk("loaduse count", 64'(stall_count), 64'd1);
    ex_regwrite = 1'b0; ex_memread = 1'b0;
    mem_regwrite = 1'b1; mem_rd = 5'd4; mem_result = 32'h55;
    step("loaduse_mem");
    chk("loaduse_mem port1", 64'(op_data[63:32]), 64'h55);

    // r0 ignores writes and never stalls.
    idle();
    wb_regwrite = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFF;
    step("wr_r0");
    idle();
    id_valid = 1'b1; id_rs = {5'd0, 5'd0}; id_rs_used = 2'b11;
    ex_regwrite = 1'b1; ex_memread = 1'b1; ex_rd = 5'd0;
    step("load_r0");
    chk("load_r0 value", 64'(op_data), 64'd0);
    idle();
    id_valid = 1'b1; id_rs = {5'd0, 5'd0}; id_rs_used = 2'b11;
    step("read_r0");
    chk("read_r0 value", 64'(op_data), 64'd0);

    // Flush beats a load-use hazard.
    idle();
    id_valid = 1'b1; id_rs = {5'd0, 5'd4}; id_rs_used = 2'b01; flush = 1'b1;
    ex_regwrite = 1'b1; ex_memread = 1'b1; ex_rd = 5'd4;
    step("flush");
    chk("flush op_valid", 64'(op_valid), 64'd0);
    chk("flush count", 64'(stall_count), 64'd1);

    // Saturate the stall counter.
    idle();
    id_valid = 1'b1; id_rs = {5'd0, 5'd9}; id_rs_used = 2'b01;
    ex_regwrite = 1'b1; ex_memread = 1'b1; ex_rd = 5'd9;
    for (int i = 0; i < (1 << CW) + 3; i++) step("sat");
    chk("sat count", 64'(stall_count), 64'hF);

    // Random traffic on a narrow address range so producers collide often.
    for (int i = 0; i < 400; i++) begin
      id_valid     = ($urandom_range(0, 3) != 0);
      id_rs        = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      id_rs_used   = 2'($urandom);
      flush        = ($urandom_range(0, 7) == 0);
      ex_regwrite  = 1'($urandom);
      ex_memread   = ($urandom_range(0, 3) == 0);
      ex_rd        = 5'($urandom_range(0, 7));
      ex_result    = $urandom;
      mem_regwrite = 1'($urandom);
      mem_rd       = 5'($urandom_range(0, 7));
      mem_result   = $urandom;
      wb_regwrite  = 1'($urandom);
      wb_rd        = 5'($urandom_range(0, 7));
      wb_data      = $urandom;
      step("rand");
    end

    // Reset in the middle of a stall clears everything at once.
    idle();
    id_valid = 1'b1; id_rs = {5'd0, 5'd2}; id_rs_used = 2'b01;
    ex_regwrite = 1'b1; ex_memread = 1'b1; ex_rd = 5'd2;
    #1 chk("pre_reset stall", 64'(stall), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("midreset stall", 64'(stall), 64'd0);
    chk("midreset op_valid", 64'(op_valid), 64'd0);
    chk("midreset op_data", 64'(op_data), 64'd0);
    chk("midreset stall_count", 64'(stall_count), 64'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    idle();
    id_valid = 1'b1; id_rs = {5'd7, 5'd3}; id_rs_used = 2'b11;
    step("post_reset");
    chk("post_reset value", 64'(op_data), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
